// File: rtl/store_unit_rmw_if.sv
// store_unit_rmw_if
// Groups the request side (datapath store path) and the data-memory port of
// the store unit into one bundle.
//   start/store_signal/addr/regData : store request, driven by the datapath
//   busy/done/misaligned            : status back to the controller
//   mem_addr/mem_rd_en/mem_rd_data  : word read port of the data memory
//   mem_wr_en/mem_wr_data           : word write port of the data memory
// Modports:
//   master : the datapath/memory side (drives requests and read data)
//   slave  : the store unit itself
`timescale 1ns/1ps
interface store_unit_rmw_if #(
    parameter int ADDR_W = 32
) ();
    logic              start;
    logic [1:0]        store_signal;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       regData;
    logic              busy;
    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;

    modport master (
        output start, store_signal, addr, regData, mem_rd_data,
        input  busy, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  start, store_signal, addr, regData, mem_rd_data,
        output busy, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/store_unit_rmw.sv
// store_unit_rmw
// Turns a register value plus a store-type code into a write to a word-wide
// data memory. sw is written directly; sh and sb read the addressed word
// first and merge the new bytes in, so the untouched bytes survive.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : store_unit_rmw_if.slave (request, status and memory port)
// store_signal: 00=sw, 01=sh, 10=sb, 11=no-op.
// Parameters:
//   READ_LATENCY : cycles from the mem_rd_en cycle to valid mem_rd_data (1..4)
//   ADDR_W       : byte address width
`timescale 1ns/1ps
module store_unit_rmw #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    store_unit_rmw_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SIG_SW   = 2'b00;
    localparam logic [1:0] SIG_SH   = 2'b01;
    localparam logic [1:0] SIG_SB   = 2'b10;
    localparam logic [1:0] SIG_NOP  = 2'b11;
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    state_t            stateReg, stateNext;
    logic [1:0]        sigReg;
    logic [ADDR_W-1:0] addrReg;
    logic [31:0]       dataReg;
    logic [31:0]       oldWordReg;
    logic [1:0]        waitCntReg;
    logic              misalignedReg;

    logic              acceptStart;
    logic              reqMisaligned;
    logic [31:0]       mergedWord;

    logic              busyNext;
    logic              doneNext;
    logic              misalignedOut;
    logic              rdEnNext;
    logic              wrEnNext;
    logic [31:0]       wrDataNext;

    // Only IDLE listens to start, so a start in any other state cannot touch
    // the latched request.
    assign acceptStart   = (stateReg == IDLE) && bus.start;
    assign reqMisaligned = ((bus.store_signal == SIG_SH) && bus.addr[0]) ||
                           ((bus.store_signal == SIG_SW) && (bus.addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg      <= IDLE;
            sigReg        <= 2'b00;
            addrReg       <= '0;
            dataReg       <= 32'd0;
            oldWordReg    <= 32'd0;
            waitCntReg    <= 2'd0;
            misalignedReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (acceptStart) begin
                sigReg        <= bus.store_signal;
                addrReg       <= bus.addr;
                dataReg       <= bus.regData;
                misalignedReg <= reqMisaligned;
            end
            if (stateReg == READ) begin
                waitCntReg <= WAIT_INIT;
            end else if ((stateReg == WAIT) && (waitCntReg != 2'd0)) begin
                waitCntReg <= waitCntReg - 2'd1;
            end
            // The read word is valid in the last WAIT cycle.
            if ((stateReg == WAIT) && (waitCntReg == 2'd0)) begin
                oldWordReg <= bus.mem_rd_data;
            end
        end
    end

    // Per-byte merge: each lane takes either its new byte or the old byte.
    // sh repeats the low halfword into both halves, sb repeats the low byte
    // into all four lanes; the lane select picks the one that is written.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       laneSel;
            logic [7:0] laneSrc;
            always_comb begin
                laneSel = 1'b0;
                laneSrc = dataReg[gi*8 +: 8];
                case (sigReg)
                    SIG_SW: begin
                        laneSel = 1'b1;
                        laneSrc = dataReg[gi*8 +: 8];
                    end
                    SIG_SH: begin
                        laneSel = (addrReg[1] == 1'(gi / 2));
                        laneSrc = dataReg[(gi % 2)*8 +: 8];
                    end
                    SIG_SB: begin
                        laneSel = (addrReg[1:0] == 2'(gi));
                        laneSrc = dataReg[7:0];
                    end
                    default: begin
                        laneSel = 1'b0;
                        laneSrc = dataReg[gi*8 +: 8];
                    end
                endcase
            end
            assign mergedWord[gi*8 +: 8] = laneSel ? laneSrc : oldWordReg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        stateNext     = stateReg;
        busyNext      = 1'b0;
        doneNext      = 1'b0;
        misalignedOut = 1'b0;
        rdEnNext      = 1'b0;
        wrEnNext      = 1'b0;
        wrDataNext    = 32'd0;
        case (stateReg)
            IDLE: begin
                if (bus.start) begin
                    if (reqMisaligned || (bus.store_signal == SIG_NOP)) begin
                        stateNext = DONE;
                    end else if (bus.store_signal == SIG_SW) begin
                        stateNext = WRITE;
                    end else begin
                        stateNext = READ;
                    end
                end
            end
            READ: begin
                busyNext  = 1'b1;
                rdEnNext  = 1'b1;
                stateNext = WAIT;
            end
            WAIT: begin
                busyNext = 1'b1;
                if (waitCntReg == 2'd0) begin
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                busyNext   = 1'b1;
                wrEnNext   = 1'b1;
                wrDataNext = mergedWord;
                stateNext  = DONE;
            end
            DONE: begin
                busyNext      = 1'b1;
                doneNext      = 1'b1;
                misalignedOut = misalignedReg;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops the strobes at once.
    assign bus.busy        = busyNext;
    assign bus.done        = doneNext;
    assign bus.misaligned  = misalignedOut;
    assign bus.mem_rd_en   = rdEnNext;
    assign bus.mem_wr_en   = wrEnNext;
    assign bus.mem_wr_data = wrDataNext;
    assign bus.mem_addr    = {addrReg[ADDR_W-1:2], 2'b00};
endmodule

// File: tb/tb_store_unit_rmw.sv
`timescale 1ns/1ps
module tb_store_unit_rmw;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;          // 0 -> unit with latency 1, 1 -> unit with latency 3
    logic [1:0]  sig;
    logic [31:0] addrIn;
    logic [31:0] dataIn;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem    [0:255];   // memory seen by the units
    logic [31:0] refMem [0:255];   // model memory

    always #5 clk = ~clk;

    store_unit_rmw_if #(.ADDR_W(32)) bus1 ();
    store_unit_rmw_if #(.ADDR_W(32)) bus3 ();

    assign bus1.start        = start & ~sel;
    assign bus3.start        = start & sel;
    assign bus1.store_signal = sig;
    assign bus3.store_signal = sig;
    assign bus1.addr         = addrIn;
    assign bus3.addr         = addrIn;
    assign bus1.regData      = dataIn;
    assign bus3.regData      = dataIn;

    store_unit_rmw #(.READ_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    store_unit_rmw #(.READ_LATENCY(3), .ADDR_W(32)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave));

    // Memory read port: data is valid exactly L cycles after the strobe cycle,
    // random garbage otherwise.
    logic [3:0]  vld1, vld3;
    logic [7:0]  ix1 [0:3];
    logic [7:0]  ix3 [0:3];
    logic [31:0] garbage;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            vld1 <= 4'd0;
            vld3 <= 4'd0;
            garbage <= 32'hDEADBEEF;
            for (int k = 0; k < 4; k++) begin
                ix1[k] <= 8'd0;
                ix3[k] <= 8'd0;
            end
        end else begin
            vld1 <= {vld1[2:0], bus1.mem_rd_en};
            vld3 <= {vld3[2:0], bus3.mem_rd_en};
            for (int k = 3; k > 0; k--) begin
                ix1[k] <= ix1[k-1];
                ix3[k] <= ix3[k-1];
            end
            ix1[0]  <= bus1.mem_addr[9:2];
            ix3[0]  <= bus3.mem_addr[9:2];
            garbage <= $urandom;
        end
    end
    assign bus1.mem_rd_data = vld1[0] ? mem[ix1[0]] : garbage;
    assign bus3.mem_rd_data = vld3[2] ? mem[ix3[2]] : garbage;

    logic        obBusy, obDone, obMis, obRd, obWr;
    logic [31:0] obAddr, obWrData;
    assign obBusy   = sel ? bus3.busy        : bus1.busy;
    assign obDone   = sel ? bus3.done        : bus1.done;
    assign obMis    = sel ? bus3.misaligned  : bus1.misaligned;
    assign obRd     = sel ? bus3.mem_rd_en   : bus1.mem_rd_en;
    assign obWr     = sel ? bus3.mem_wr_en   : bus1.mem_wr_en;
    assign obAddr   = sel ? bus3.mem_addr    : bus1.mem_addr;
    assign obWrData = sel ? bus3.mem_wr_data : bus1.mem_wr_data;

    // ---------------- reference model ----------------
    function automatic logic isMis(input logic [1:0] s, input logic [31:0] a);
        return ((s == 2'd1) && (a % 2 == 1)) || ((s == 2'd0) && (a % 4 != 0));
    endfunction

    function automatic int expDone(input int lat, input logic [1:0] s, input logic [31:0] a);
        if (isMis(s, a) || s == 2'd3) return 1;
        if (s == 2'd0) return 2;
        return 3 + lat;
    endfunction

    function automatic logic [31:0] expWord(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] d, input logic [31:0] old);
        int sh;
        if (s == 2'd0) return d;
        if (s == 2'd1) begin
            sh = ((a / 2) % 2) * 16;
            return (old & ~(32'h0000FFFF << sh)) | ((d & 32'h0000FFFF) << sh);
        end
        sh = (a % 4) * 8;
        return (old & ~(32'h000000FF << sh)) | ((d & 32'h000000FF) << sh);
    endfunction

    function automatic logic [31:0] expBusy(input int n);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 1; i <= n; i++) m[i] = 1'b1;
        return m;
    endfunction

    // ---------------- transaction driver ----------------
    int          rDone, rRd, rWr, rWrCycle;
    logic        rMis, rBad, rPostBusy;
    logic [31:0] rWrData, rWrAddr, rRdAddr, rBusyMask;

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        mem[a[9:2]]    = w;
        refMem[a[9:2]] = w;
    endtask

    // Called at a negedge; start is raised for one edge, then the inputs are
    // scrambled every cycle. 'inject' pulses start again in that cycle.
    task automatic run_op(input logic which, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input int inject);
        sel = which; sig = s; addrIn = a; dataIn = d; start = 1'b1;
        rDone = 0; rRd = 0; rWr = 0; rWrCycle = 0; rMis = 1'b0; rBad = 1'b0;
        rPostBusy = 1'b0; rWrData = 32'd0; rWrAddr = 32'd0; rRdAddr = 32'd0; rBusyMask = 32'd0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            rBusyMask[c] = obBusy;
            if (obRd) begin rRd++; rRdAddr = obAddr; end
            if (obWr) begin
                rWr++; rWrData = obWrData; rWrAddr = obAddr; rWrCycle = c;
                mem[obAddr[9:2]] = obWrData;
            end
            if (obRd && obWr) rBad = 1'b1;
            if (!obWr && obWrData != 32'd0) rBad = 1'b1;
            if (!obDone && obMis) rBad = 1'b1;
            if (obDone) begin rDone = c; rMis = obMis; end
            start  = (c == inject);
            sig    = 2'($urandom);
            addrIn = $urandom;
            dataIn = $urandom;
            if (obDone) break;
        end
        @(negedge clk);
        rPostBusy = obBusy | obDone;
        start = 1'b0;
        $display("op unit=L%0d sig=%0d addr=%h data=%h -> done@%0d mis=%0d rd=%0d wr=%0d wdata=%h waddr=%h",
                 which ? 3 : 1, s, a, d, rDone, rMis, rRd, rWr, rWrData, rWrAddr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sel = 1'b0; sig = 2'd0; addrIn = 32'd0; dataIn = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.done, bus1.misaligned, bus1.mem_rd_en, bus1.mem_wr_en} !== 5'd0 ||
            bus1.mem_addr !== 32'd0 || bus1.mem_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs_L1: got busy=%b done=%b mis=%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                     bus1.busy, bus1.done, bus1.misaligned, bus1.mem_rd_en, bus1.mem_wr_en,
                     bus1.mem_addr, bus1.mem_wr_data);
        end
        checks++;
        if ({bus3.busy, bus3.done, bus3.misaligned, bus3.mem_rd_en, bus3.mem_wr_en} !== 5'd0 ||
            bus3.mem_addr !== 32'd0 || bus3.mem_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs_L3: got busy=%b done=%b mis=%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                     bus3.busy, bus3.done, bus3.misaligned, bus3.mem_rd_en, bus3.mem_wr_en,
                     bus3.mem_addr, bus3.mem_wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store();
        set_word(32'h10, 32'hFFFFFFFF);
        run_op(1'b0, 2'd0, 32'h10, 32'h12345678, 0);
        refMem[4] = 32'h12345678;
        checks++;
        if (rWrCycle !== 1 || rWr !== 1 || rRd !== 0) begin
            errors++;
            $display("FAIL sw_strobes: got wrCycle=%0d wr=%0d rd=%0d want 1 1 0", rWrCycle, rWr, rRd);
        end
        checks++;
        if (rWrData !== 32'h12345678 || rWrAddr !== 32'h10) begin
            errors++;
            $display("FAIL sw_write: got data=%h addr=%h want 12345678 00000010", rWrData, rWrAddr);
        end
        checks++;
        if (rDone !== 2 || rBusyMask !== expBusy(2)) begin
            errors++;
            $display("FAIL sw_timing: got done=%0d busy=%h want 2 %h", rDone, rBusyMask, expBusy(2));
        end
    endtask

    task automatic test_byte_store();
        set_word(32'h10, 32'hFFFFFFFF);
        run_op(1'b0, 2'd2, 32'h12, 32'h000000AB, 0);
        refMem[4] = 32'hFFABFFFF;
        checks++;
        if (rRd !== 1 || rRdAddr !== 32'h10 || rWr !== 1 || rWrData !== 32'hFFABFFFF) begin
            errors++;
            $display("FAIL sb_rmw: got rd=%0d raddr=%h wr=%0d data=%h want 1 00000010 1 ffabffff",
                     rRd, rRdAddr, rWr, rWrData);
        end
        checks++;
        if (rDone !== 4 || rBusyMask !== 32'h1E) begin
            errors++;
            $display("FAIL sb_timing: got done=%0d busy=%h want 4 0000001e", rDone, rBusyMask);
        end
    endtask

    task automatic test_halfword();
        set_word(32'h14, 32'h00000000);
        run_op(1'b0, 2'd1, 32'h16, 32'hFFFFBEEF, 0);
        refMem[5] = 32'hBEEF0000;
        checks++;
        if (rWrData !== 32'hBEEF0000 || rWrAddr !== 32'h14 || rWr !== 1) begin
            errors++;
            $display("FAIL sh_write: got data=%h addr=%h wr=%0d want beef0000 00000014 1",
                     rWrData, rWrAddr, rWr);
        end
        run_op(1'b0, 2'd1, 32'h15, 32'hFFFFBEEF, 0);
        checks++;
        if (rDone !== 1 || rMis !== 1'b1 || rRd !== 0 || rWr !== 0) begin
            errors++;
            $display("FAIL sh_misaligned: got done=%0d mis=%b rd=%0d wr=%0d want 1 1 0 0",
                     rDone, rMis, rRd, rWr);
        end
    endtask

    task automatic test_noop_and_ignored_start();
        logic [31:0] want;
        run_op(1'b0, 2'd3, 32'h40, 32'h55AA55AA, 0);
        checks++;
        if (rDone !== 1 || rMis !== 1'b0 || rRd !== 0 || rWr !== 0) begin
            errors++;
            $display("FAIL noop: got done=%0d mis=%b rd=%0d wr=%0d want 1 0 0 0", rDone, rMis, rRd, rWr);
        end
        // start pulsed during WAIT with scrambled inputs
        want = expWord(2'd2, 32'h31, 32'h0000005A, refMem[12]);
        run_op(1'b0, 2'd2, 32'h31, 32'h0000005A, 2);
        refMem[12] = want;
        checks++;
        if (rWr !== 1 || rWrData !== want || rWrAddr !== 32'h30 || rDone !== 4 || rPostBusy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_L1: got wr=%0d data=%h addr=%h done=%0d post=%b want 1 %h 00000030 4 0",
                     rWr, rWrData, rWrAddr, rDone, rPostBusy, want);
        end
        want = expWord(2'd2, 32'h33, 32'h000000C3, refMem[12]);
        run_op(1'b1, 2'd2, 32'h33, 32'h000000C3, 3);
        refMem[12] = want;
        checks++;
        if (rWr !== 1 || rWrData !== want || rDone !== 6 || rPostBusy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_L3: got wr=%0d data=%h done=%0d post=%b want 1 %h 6 0",
                     rWr, rWrData, rDone, rPostBusy, want);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 2'd0, 32'h80, 32'hCAFEF00D, 2);   // start during DONE
        refMem[32] = 32'hCAFEF00D;
        checks++;
        if (rDone !== 2 || rPostBusy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_in_done: got done=%0d post_busy=%b want 2 0", rDone, rPostBusy);
        end
        run_op(1'b0, 2'd0, 32'h84, 32'h0BADF00D, 0);   // accepted the very next cycle
        refMem[33] = 32'h0BADF00D;
        checks++;
        if (rDone !== 2 || rWrData !== 32'h0BADF00D || rWrAddr !== 32'h84) begin
            errors++;
            $display("FAIL b2b_next_accept: got done=%0d data=%h addr=%h want 2 0badf00d 00000084",
                     rDone, rWrData, rWrAddr);
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        seen = 1'b0;
        set_word(32'h60, 32'h11111111);
        sel = 1'b1; sig = 2'd2; addrIn = 32'h61; dataIn = 32'h000000EE; start = 1'b1;
        @(negedge clk);                  // cycle 1 (READ)
        start = 1'b0;
        @(negedge clk);                  // cycle 2 (WAIT)
        @(negedge clk);                  // cycle 3 (WAIT)
        checks++;
        if (bus3.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_before: got %b want 1", bus3.busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus3.busy, bus3.done, bus3.misaligned, bus3.mem_rd_en, bus3.mem_wr_en} !== 5'd0 ||
            bus3.mem_addr !== 32'd0 || bus3.mem_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%b done=%b mis=%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                     bus3.busy, bus3.done, bus3.misaligned, bus3.mem_rd_en, bus3.mem_wr_en,
                     bus3.mem_addr, bus3.mem_wr_data);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus3.mem_wr_en || bus3.done) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus3.mem_wr_en || bus3.done || bus3.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abandon: got write/done/busy after reset=%b want 0", seen);
        end
        run_op(1'b1, 2'd0, 32'h64, 32'hA5A5A5A5, 0);
        refMem[25] = 32'hA5A5A5A5;
        checks++;
        if (rDone !== 2 || rWr !== 1 || rWrData !== 32'hA5A5A5A5 || rWrAddr !== 32'h64) begin
            errors++;
            $display("FAIL rst_mid_next_sw: got done=%0d wr=%0d data=%h addr=%h want 2 1 a5a5a5a5 00000064",
                     rDone, rWr, rWrData, rWrAddr);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] want [0:3];
        want[0] = 32'h112233EE; want[1] = 32'h1122EE44;
        want[2] = 32'h11EE3344; want[3] = 32'hEE223344;
        for (int k = 0; k < 4; k++) begin
            set_word(32'h20, 32'h11223344);
            run_op(k[0], 2'd2, 32'h20 + k, 32'h000000EE, 0);
            refMem[8] = want[k];
            checks++;
            if (rWrData !== want[k] || rWr !== 1 || rDone !== (k[0] ? 6 : 4)) begin
                errors++;
                $display("FAIL sb_lane%0d: got data=%h wr=%0d done=%0d want %h 1 %0d",
                         k, rWrData, rWr, rDone, want[k], k[0] ? 6 : 4);
            end
        end
    endtask

    task automatic test_random();
        logic        u;
        logic [1:0]  s;
        logic [31:0] a, d, want;
        int          inj, lat, nd;
        logic        writes;
        for (int n = 0; n < 40; n++) begin
            u   = 1'($urandom);
            s   = 2'($urandom);
            a   = $urandom_range(0, 1023);
            d   = $urandom;
            inj = $urandom_range(0, 7);
            lat = u ? 3 : 1;
            nd  = expDone(lat, s, a);
            writes = !(isMis(s, a) || s == 2'd3);
            want = expWord(s, a, d, refMem[a[9:2]]);
            run_op(u, s, a, d, inj);
            if (writes) refMem[a[9:2]] = want;
            checks++;
            if (rDone !== nd || rMis !== isMis(s, a) || rBusyMask !== expBusy(nd)) begin
                errors++;
                $display("FAIL rnd%0d_timing: got done=%0d mis=%b busy=%h want %0d %b %h",
                         n, rDone, rMis, rBusyMask, nd, isMis(s, a), expBusy(nd));
            end
            checks++;
            if (rWr !== (writes ? 1 : 0) || rRd !== ((writes && s != 2'd0) ? 1 : 0)) begin
                errors++;
                $display("FAIL rnd%0d_strobes: got wr=%0d rd=%0d want %0d %0d",
                         n, rWr, rRd, writes ? 1 : 0, (writes && s != 2'd0) ? 1 : 0);
            end
            if (writes) begin
                checks++;
                if (rWrData !== want || rWrAddr !== {a[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rnd%0d_data: got data=%h addr=%h want %h %h",
                             n, rWrData, rWrAddr, want, {a[31:2], 2'b00});
                end
            end
            checks++;
            if (rBad !== 1'b0 || rPostBusy !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_hygiene: got bad=%b post_busy=%b want 0 0", n, rBad, rPostBusy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        test_reset();
        test_word_store();
        test_byte_store();
        test_halfword();
        test_noop_and_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        test_byte_lanes();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_unit_rmw.md
Name: store_unit_rmw

Overview:
- Store-side counterpart of the load unit: converts register data plus a store-type code into a memory write.
- Word stores (sw) are written directly.
- Halfword and byte stores (sh, sb) use a read-modify-write sequence to a word-wide data memory, so untouched bytes are preserved.
- Sits between the datapath store path and the data memory port; the controller holds the pipeline while busy is high.

Parameters:
- READ_LATENCY, 1: cycles from the mem_rd_en cycle until mem_rd_data is valid (legal range 1 to 4).
- ADDR_W, 32: byte address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- store_signal  input  2  store type: 00=sw, 01=sh, 10=sb, 11=no-op.
- addr  input  ADDR_W  byte address of the store.
- regData  input  32  rt register value; the low bits are used for sh and sb.
- busy  output  1  high from the cycle after an accepted start until DONE, inclusive.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  valid with done; 1 = sh with addr[0]=1 or sw with addr[1:0]!=0.
- mem_addr  output  ADDR_W  word address: latched addr with bits [1:0] forced to 00.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rd_data  input  32  memory read word.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wr_data  output  32  merged word to write.

Behaviour:
- Reset
  - Asynchronous reset forces state to IDLE.
  - All outputs are 0: busy, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data.
  - The internal latches and the wait counter are cleared.
- Start acceptance
  - In IDLE, start=1 at a clock edge latches store_signal, addr and regData.
  - All later behaviour uses the latched copies, so the inputs may change freely afterwards.
  - start in any state other than IDLE is ignored; it is neither queued nor able to corrupt the latches.
- States: IDLE, READ, WAIT, WRITE, DONE.
- Transitions out of IDLE on an accepted start:
  - misaligned request -> DONE with misaligned=1; no memory access is made.
  - 11 (no-op) -> DONE with misaligned=0; no memory access is made.
  - 00 (sw) -> WRITE.
  - 01 or 10 (sh or sb) -> READ.
- READ: mem_rd_en=1 for exactly 1 cycle, then WAIT.
- WAIT
  - Counter runs from READ_LATENCY-1 down to 0.
  - mem_rd_data is captured into the old-word register at the edge leaving WAIT.
  - Next state is WRITE.
- WRITE: mem_wr_en=1 for exactly 1 cycle, then DONE. mem_wr_data is:
  - sw: regData.
  - sh: regData[15:0] placed in lane addr[1] (little-endian; lane 0 = bits 15:0). The other half comes from the old word.
  - sb: regData[7:0] placed at bits addr[1:0]*8+7 : addr[1:0]*8. The other three bytes come from the old word.
- DONE: done=1 for 1 cycle, then IDLE. misaligned holds its value only during DONE and is 0 otherwise.
- Cycle counts, with cycle 0 being the accepted-start edge:
  - sw: WRITE in cycle 1, done in cycle 2.
  - sh/sb: READ in cycle 1, WAIT in cycles 2..1+L, WRITE in cycle 2+L, done in cycle 3+L (L = READ_LATENCY).
  - no-op and misaligned: done in cycle 1.
- Output validity
  - mem_addr is valid and stable from READ through WRITE.
  - mem_wr_data is 0 outside WRITE.
  - mem_rd_en and mem_wr_en are never high in the same cycle.
  - Exactly one write occurs per non-error, non-no-op request.
- Reset during an operation
  - Returns to IDLE immediately.
  - A pending write is abandoned, and mem_wr_en drops asynchronously.
  - No done pulse is issued.
- A back-to-back start arriving in the same cycle as done (i.e. while in DONE) is ignored. A new start is accepted from IDLE on the next cycle.

Test Plan:
- Word store: memory word = FFFFFFFF, sw addr=0x10, regData=12345678.
  - Required: write in cycle 1, mem_wr_data=12345678, mem_addr=0x10, no read, done in cycle 2.
- Byte store with L=1: memory = FFFFFFFF, sb addr=0x12, regData=000000AB.
  - Required: read, then write FFABFFFF.
  - Required: done in cycle 4, busy high in cycles 1-4.
- Halfword store: memory = 00000000, sh addr=0x16, regData=FFFFBEEF.
  - Required: mem_wr_data=BEEF0000, mem_addr=0x14.
  - Repeat with addr=0x15: required done with misaligned=1 in cycle 1, and no rd_en or wr_en ever asserted.
- No-op and ignored starts: store_signal=11.
  - Required: done in cycle 1, no memory strobes.
  - Also pulse start during WAIT of an sb: required no effect on the latched data and a single write only.
- Reset mid-operation with READ_LATENCY=3: assert reset during WAIT of an sb.
  - Required: all outputs 0 immediately, no mem_wr_en, no done, state IDLE.
  - Next sw then completes normally.
- All byte lanes: sb to lanes 0-3 on memory 11223344 with regData=000000EE.
  - Required writes: 112233EE, 1122EE44, 11EE3344, EE223344.
